// File: rtl/imm_gen_pipe.sv
// Registered RV32I/RV64I immediate generator with a two-entry valid/ready skid buffer.
// Decodes in_instr combinationally and captures the result, instruction and tag on accept.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32,
  parameter bit ZICSR = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic             out_illegal,
  output logic [31:0]      out_instr,
  output logic [TAG_W-1:0] out_tag
);

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_chk
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  localparam bit IS64 = (XLEN == 64);

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_FENCE    = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM32  = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_I    = 3'b000,
    IMM_S    = 3'b001,
    IMM_B    = 3'b010,
    IMM_J    = 3'b011,
    IMM_U    = 3'b100,
    IMM_Z    = 3'b101,
    IMM_NONE = 3'b111
  } imm_type_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_type_e        typ;
    logic             ill;
    logic [31:0]      instr;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_z;
  logic [XLEN-1:0] dec_imm;
  imm_type_e       dec_typ;
  logic            dec_ill;
  entry_t          new_e;

  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_vld_q, main_vld_d;
  logic   skid_vld_q, skid_vld_d;
  logic   acc_w, rel_w;

  // Size casts of signed operands sign-extend from instr[31] to XLEN.
  assign imm_i = XLEN'($signed(in_instr[31:20]));
  assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                in_instr[11:8], 1'b0}));
  assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                in_instr[30:21], 1'b0}));
  assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign imm_z = XLEN'(in_instr[19:15]);

  always_comb begin
    dec_imm = '0;
    dec_typ = IMM_NONE;
    dec_ill = 1'b0;
    case (in_instr[6:0])
      OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
        dec_imm = imm_i;
        dec_typ = IMM_I;
      end
      OPC_OPIMM32: begin
        if (IS64) begin
          dec_imm = imm_i;
          dec_typ = IMM_I;
        end else begin
          dec_ill = 1'b1;
        end
      end
      OPC_STORE: begin
        dec_imm = imm_s;
        dec_typ = IMM_S;
      end
      OPC_BRANCH: begin
        dec_imm = imm_b;
        dec_typ = IMM_B;
      end
      OPC_JAL: begin
        dec_imm = imm_j;
        dec_typ = IMM_J;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_imm = imm_u;
        dec_typ = IMM_U;
      end
      OPC_SYSTEM: begin
        if (ZICSR && in_instr[14]) begin
          dec_imm = imm_z;
          dec_typ = IMM_Z;
        end
      end
      OPC_OP, OPC_FENCE: ;
      OPC_OP32: dec_ill = !IS64;
      // Also catches every word with instr[1:0] != 2'b11.
      default: dec_ill = 1'b1;
    endcase
  end

  assign new_e = '{imm: dec_imm, typ: dec_typ, ill: dec_ill, instr: in_instr, tag: in_tag};

  assign in_ready = !skid_vld_q;
  assign acc_w    = in_valid && in_ready;
  assign rel_w    = main_vld_q && out_ready;

  // A release with skid full cannot coincide with an accept: in_ready is low then.
  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (rel_w) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else if (acc_w) begin
        main_d     = new_e;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (acc_w) begin
      if (!main_vld_q) begin
        main_d     = new_e;
        main_vld_d = 1'b1;
      end else begin
        skid_d     = new_e;
        skid_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign out_valid   = main_vld_q;
  assign out_imm     = main_q.imm;
  assign out_type    = main_q.typ;
  assign out_illegal = main_q.ill;
  assign out_instr   = main_q.instr;
  assign out_tag     = main_q.tag;

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, flow-controlled immediate generator for the decode stage. Accepts one RV32I/RV64I instruction word per cycle with an opaque tag (typically the PC). Emits the sign-extended immediate, an immediate-type code and an illegal-opcode flag one cycle later through a valid/ready skid buffer, so fetch and execute can stall independently. It generalises the combinational extender:

- parametrised XLEN
- optional CSR zimm support
- RV64 OP-IMM-32
- flush
- backpressure

## Interface

Parameters:
- XLEN, 32: datapath width; only 32 or 64 are legal. Any other value triggers an elaboration-time `$error`.
- TAG_W, 32: width of the sideband tag carried with each instruction.
- ZICSR, 1: 1 decodes SYSTEM (1110011) funct3[2]=1 as the Z-type 5-bit CSR immediate; 0 treats SYSTEM as "no immediate".

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- flush, input, 1: synchronous pipeline flush.
- in_valid, input, 1: instruction offered.
- in_ready, output, 1: block can accept this cycle.
- in_instr, input, 32: instruction word.
- in_tag, input, TAG_W: sideband data passed through unchanged.
- out_valid, output, 1: result available.
- out_ready, input, 1: consumer takes result this cycle.
- out_imm, output, XLEN: extended immediate.
- out_type, output, 3: immediate type (see below).
- out_illegal, output, 1: opcode not recognised.
- out_instr, output, 32: registered copy of the instruction word.
- out_tag, output, TAG_W: registered copy of the tag.

## Operation

**Decode** (combinational on in_instr, registered on accept). Immediates are sign-extended from instr[31] to XLEN unless stated otherwise.
- LOAD 0000011, OP-IMM 0010011, JALR 1100111, and OP-IMM-32 0011011 (XLEN=64 only) → I-type, type 000.
  - imm = sext(instr[31:20]).
  - Shift encodings are not special-cased.
- STORE 0100011 → S-type, type 001.
  - imm = sext({instr[31:25], instr[11:7]}).
- BRANCH 1100011 → B-type, type 010.
  - imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
- JAL 1101111 → J-type, type 011.
  - imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
- LUI 0110111, AUIPC 0010111 → U-type, type 100.
  - imm = sext({instr[31:12], 12'b0}) to XLEN; for XLEN=32 no extension bits are added.
- SYSTEM with ZICSR=1 and funct3[2]=1 → Z-type, type 101.
  - imm = zero-extended instr[19:15].
- OP 0110011, FENCE 0001111, OP-32 0111011 (XLEN=64), and remaining SYSTEM encodings → type 111, imm = 0, legal.
- Anything else, including instr[1:0] ≠ 11 and OP-IMM-32/OP-32 when XLEN=32 → type 111, imm = 0, out_illegal = 1.

**Flow control**: two-entry skid buffer made of a main output register and a skid register.
- Accept occurs when in_valid && in_ready.
- Release occurs when out_valid && out_ready.
- in_ready = !skid_valid. It is a registered signal with no combinational path from out_ready.
- Accept while main is empty, or while main is being released with skid empty → data goes to main.
- Accept while main is full and not released → data goes to skid.
- Release while skid is full → skid moves to main; skid empties.
- Order is strictly FIFO. Output fields hold stable while out_valid && !out_ready.

**Flush**:
- Clears main and skid valid in the cycle it is sampled.
- Overrides a same-cycle accept; that instruction is dropped.
- Overrides a same-cycle release; the release still counts as consumed.
- in_ready = 1 the cycle after a flush.

## Timing

- Latency is 1 cycle: an instruction accepted at edge N appears with out_valid = 1 after edge N.
- Throughput is 1 per cycle while out_ready = 1.
- Reset (rst_n low, asynchronous) forces:
  - out_valid = 0, skid empty, in_ready = 1;
  - out_imm, out_type, out_instr, out_tag, out_illegal to 0.
- Reset deassertion is synchronised externally; the first accept is possible on the first edge with rst_n high.
- Reset mid-stream discards both entries immediately, without waiting for a clock edge.
- Full condition: with skid occupied, in_ready = 0 from the edge after the skid fill.
- Simultaneous release and accept while skid is full is impossible, because in_ready = 0 in that state.

## Test plan

1. **XLEN=32 type coverage**: each input is presented one per cycle and must give the listed outputs.
   - 0xFFF00093 (addi x1,x0,-1) → imm 0xFFFFFFFF, type 000.
   - 0xFE000EE3 (beq, −4) → imm 0xFFFFFFFC, type 010.
   - 0x123450B7 (lui) → imm 0x12345000, type 100.
   - 0x001000EF (jal +2048) → imm 0x00000800, type 011.
   - 0x000FD073 (csrrwi zimm=31) → imm 0x0000001F, type 101.
2. **Illegal opcodes**:
   - 0x00000000 → illegal = 1, imm 0, type 111.
   - 0x0000001B with XLEN=32 → illegal = 1.
3. **XLEN=64**:
   - 0x800000B7 → imm 0xFFFFFFFF80000000.
   - 0xFFF0009B (addiw) → imm all-ones, illegal = 0.
4. **Backpressure**: hold out_ready = 0 and offer tags 1, 2, 3 on consecutive cycles.
   - Tags 1 and 2 are accepted; in_ready drops after the second accept; outputs stay frozen on tag 1.
   - When out_ready = 1: tags 1, 2, 3 emerge on consecutive cycles with no loss or duplication.
5. **Flush**: with both entries full, assert flush together with in_valid.
   - Next cycle: out_valid = 0, in_ready = 1; the flushed-cycle instruction never appears.
6. **Async reset mid-stream**: drop rst_n between clock edges while out_valid = 1.
   - Outputs go to 0 without a clock edge.
   - After release, the first accepted instruction emerges with 1-cycle latency.
